// File: rtl/rotary_decoder.sv
// rotary_decoder: debounced quadrature decoder with push switch, step/press pulses and cursor position.
// Define ROTARY_DECODER_WRAP_EN for a wrap-around cursor; by default the cursor saturates at 0 and POS_MAX.
module rotary_decoder #(
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter int POS_MAX = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rotary_a,
  input  logic                         rotary_b,
  input  logic                         rotary_sw,
  output logic                         step_cw,
  output logic                         step_ccw,
  output logic [$clog2(POS_MAX+1)-1:0] position,
  output logic                         sw_level,
  output logic                         sw_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int POS_W = $clog2(POS_MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
  typedef enum logic [3:0] {WAIT, IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR} state_t;
  state_t state, nxt;
  logic [2:0] raw, s1, s2, stb;
  logic [CNT_W-1:0] cnt [3];
  logic [1:0] ab;
  logic step_cw_nxt, step_ccw_nxt, sw_level_d;
  logic [POS_W-1:0] pos_inc, pos_dec;
  assign raw = {rotary_sw, rotary_a, rotary_b};
  assign ab = stb[1:0];
  assign sw_level = ~stb[2];
  // Two-flop synchronizer plus per-input stability counter; all idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      stb <= '1;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int k = 0; k < 3; k++) begin
        if (s2[k] == stb[k]) cnt[k] <= '0;
        else if (cnt[k] == LAST) begin
          stb[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      WAIT: nxt = ab == 2'b11 ? IDLE : WAIT;
      IDLE: nxt = ab == 2'b01 ? CW1 : ab == 2'b10 ? CCW1 : ab == 2'b00 ? ERR : IDLE;
      CW1:  nxt = ab == 2'b00 ? CW2 : ab == 2'b11 ? IDLE : ab == 2'b10 ? ERR : CW1;
      CW2:  nxt = ab == 2'b10 ? CW3 : ab == 2'b01 ? CW1 : ab == 2'b11 ? ERR : CW2;
      CW3:  nxt = ab == 2'b11 ? IDLE : ab == 2'b00 ? CW2 : ab == 2'b01 ? ERR : CW3;
      CCW1: nxt = ab == 2'b00 ? CCW2 : ab == 2'b11 ? IDLE : ab == 2'b01 ? ERR : CCW1;
      CCW2: nxt = ab == 2'b01 ? CCW3 : ab == 2'b10 ? CCW1 : ab == 2'b11 ? ERR : CCW2;
      CCW3: nxt = ab == 2'b11 ? IDLE : ab == 2'b00 ? CCW2 : ab == 2'b10 ? ERR : CCW3;
      ERR:  nxt = ab == 2'b11 ? IDLE : ERR;
      default: nxt = WAIT;
    endcase
  end
  always_comb begin
    step_cw_nxt = state == CW3 && ab == 2'b11;
    step_ccw_nxt = state == CCW3 && ab == 2'b11;
  end
`ifdef ROTARY_DECODER_WRAP_EN
  assign pos_inc = position == PMAX ? '0 : position + POS_W'(1);
  assign pos_dec = position == '0 ? PMAX : position - POS_W'(1);
`else
  assign pos_inc = position == PMAX ? position : position + POS_W'(1);
  assign pos_dec = position == '0 ? position : position - POS_W'(1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cw <= 1'b0;
      step_ccw <= 1'b0;
      position <= '0;
      sw_level_d <= 1'b0;
      sw_press <= 1'b0;
    end else begin
      step_cw <= step_cw_nxt;
      step_ccw <= step_ccw_nxt;
      position <= step_cw_nxt ? pos_inc : step_ccw_nxt ? pos_dec : position;
      sw_level_d <= sw_level;
      sw_press <= sw_level & ~sw_level_d;
    end
  end
endmodule

// File: tb/tb_rotary_decoder.sv
// tb_rotary_decoder: scoreboard bench; stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_rotary_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rotary_a = 1'b1, rotary_b = 1'b1, rotary_sw = 1'b1;
  logic step_cw, step_ccw, sw_level, sw_press;
  logic [2:0] position;
  int cyc = 0, checks = 0, errors = 0;
  int pos_m = 0;
`ifdef ROTARY_DECODER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef struct {logic cw; int pos; int cyc;} ev_t;
  ev_t q_rot[$];
  int q_sw[$];

  rotary_decoder #(.DEBOUNCE_CYCLES(4), .POS_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n), .rotary_a(rotary_a), .rotary_b(rotary_b), .rotary_sw(rotary_sw),
    .step_cw(step_cw), .step_ccw(step_ccw), .position(position), .sw_level(sw_level), .sw_press(sw_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    ev_t e;
    int c;
    if (step_cw && step_ccw) begin
      checks++;
      errors++;
      $display("FAIL both_steps step_cw=1 step_ccw=1 at cycle %0d, required never both", cyc);
    end
    if (step_cw || step_ccw) begin
      checks++;
      if (q_rot.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step cw=%0b ccw=%0b pos=%0d at cycle %0d", step_cw, step_ccw, position, cyc);
      end else begin
        e = q_rot.pop_front();
        if (step_cw !== e.cw || int'(position) != e.pos || cyc != e.cyc) begin
          errors++;
          $display("FAIL step got cw=%0b pos=%0d cycle=%0d, required cw=%0b pos=%0d cycle=%0d",
                   step_cw, position, cyc, e.cw, e.pos, e.cyc);
        end
      end
    end
    if (sw_press) begin
      checks++;
      if (q_sw.size() == 0) begin
        errors++;
        $display("FAIL unexpected_press at cycle %0d", cyc);
      end else begin
        c = q_sw.pop_front();
        if (cyc != c) begin
          errors++;
          $display("FAIL press_cycle got %0d required %0d", cyc, c);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] ab);
    @(posedge clk);
    #1;
    {rotary_a, rotary_b} = ab;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    put(ab);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic detent(input logic cw);
    ev_t e;
    hold(cw ? 2'b01 : 2'b10, 10);
    hold(2'b00, 10);
    hold(cw ? 2'b10 : 2'b01, 10);
    put(2'b11);
    if (cw) pos_m = pos_m == 7 ? (WRAP ? 0 : 7) : pos_m + 1;
    else pos_m = pos_m == 0 ? (WRAP ? 7 : 0) : pos_m - 1;
    e.cw = cw;
    e.pos = pos_m;
    e.cyc = cyc + 7;
    q_rot.push_back(e);
    repeat (9) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_step_cw", int'(step_cw), 0);
    chk("rst_step_ccw", int'(step_ccw), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_sw_level", int'(sw_level), 0);
    chk("rst_sw_press", int'(sw_press), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos_m = 0;
    repeat (12) @(posedge clk);
  endtask

  task automatic glitch_a(input int n);
    put(2'b01);
    repeat (n - 1) @(posedge clk);
    put(2'b11);
    repeat (12) @(posedge clk);
  endtask

  task automatic chk_pos(input string name, input int exp);
    @(negedge clk);
    chk(name, int'(position), exp);
  endtask

  initial begin
    int t;
    do_reset();
    detent(1'b1);
    chk_pos("cw_one", 1);
    detent(1'b0);
    chk_pos("ccw_back", 0);
    detent(1'b0);
    chk_pos("ccw_at_zero", WRAP ? 7 : 0);
    do_reset();
    repeat (8) detent(1'b1);
    chk_pos("eight_cw", WRAP ? 0 : 7);
    glitch_a(2);
    glitch_a(3);
    hold(2'b01, 10);
    hold(2'b00, 10);
    hold(2'b01, 10);
    hold(2'b11, 10);
    chk_pos("glitch_half", WRAP ? 0 : 7);
    hold(2'b00, 10);
    hold(2'b11, 10);
    chk_pos("illegal_jump", WRAP ? 0 : 7);
    detent(1'b1);
    chk_pos("after_illegal", WRAP ? 1 : 7);
    hold(2'b01, 10);
    hold(2'b00, 10);
    do_reset();
    hold(2'b10, 10);
    hold(2'b11, 10);
    chk_pos("mid_detent_reset", 0);
    detent(1'b1);
    chk_pos("recover_cw", 1);
    @(posedge clk);
    #1;
    rotary_sw = 1'b0;
    t = cyc;
    q_sw.push_back(t + 7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sw_level_edge5", int'(sw_level), 0);
    @(negedge clk);
    chk("sw_level_edge6", int'(sw_level), 1);
    repeat (3) @(posedge clk);
    #1;
    rotary_sw = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("sw_released", int'(sw_level), 0);
    repeat (10) @(posedge clk);
    chk("rot_queue_empty", q_rot.size(), 0);
    chk("sw_queue_empty", q_sw.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
